// File: rtl/writeback_ls_if.sv
// Writeback-stage bus: memory-stage results in, register-file write port and
// jump/stall/error indications out.
interface writeback_ls_if #(
  parameter int XLEN  = 32,
  parameter int OPLEN = 8
);
  logic             phase_writeback;
  logic             jump_state_mw;
  logic [OPLEN-1:0] decoded_op_mw;
  logic [4:0]       rdsel_mw;
  logic [2:0]       funct3_mw;
  logic [1:0]       mem_off_mw;
  logic [XLEN-1:0]  next_pc_mw;
  logic [XLEN-1:0]  alu_out_mw;
  logic [XLEN-1:0]  mem_out_mw;
  logic             mem_valid;
  logic [XLEN-1:0]  rddata_wr;
  logic [4:0]       rdsel_wr;
  logic             rdwe_wr;
  logic [XLEN-1:0]  regdata_for_pc;
  logic             jump_state_wf;
  logic             stall_writeback;
  logic             mem_err;

  modport master (
    output phase_writeback, jump_state_mw, decoded_op_mw, rdsel_mw, funct3_mw,
           mem_off_mw, next_pc_mw, alu_out_mw, mem_out_mw, mem_valid,
    input  rddata_wr, rdsel_wr, rdwe_wr, regdata_for_pc, jump_state_wf,
           stall_writeback, mem_err
  );

  modport slave (
    input  phase_writeback, jump_state_mw, decoded_op_mw, rdsel_mw, funct3_mw,
           mem_off_mw, next_pc_mw, alu_out_mw, mem_out_mw, mem_valid,
    output rddata_wr, rdsel_wr, rdwe_wr, regdata_for_pc, jump_state_wf,
           stall_writeback, mem_err
  );
endinterface

// File: rtl/writeback_ls.sv
// Writeback stage: selects the result source, extends load data, waits for
// late memory data with a bounded timeout, and issues a one-cycle commit.
module writeback_ls #(
  parameter int XLEN          = 32,
  parameter int MEM_TIMEOUT   = 15,
  // Decoded-op layout, mirroring core_general.vh
  parameter int OPLEN         = 8,
  parameter int JUMP_EN_BIT   = 3,
  parameter int USE_RD_BIT_M  = 2,
  parameter int USE_RD_BIT_L  = 0,
  parameter int USE_RD_ALU    = 1,
  parameter int USE_RD_PC     = 2,
  parameter int USE_RD_MEMORY = 3,
  parameter int USE_RD_COMP   = 4
) (
  input logic         clk,
  input logic         rst,
  writeback_ls_if.slave wb
);

  localparam int UW = USE_RD_BIT_M - USE_RD_BIT_L + 1;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      count_reg, count_next;
  logic            capture, enter_commit, abort, stall;

  logic [UW-1:0]   use_rd_reg;
  logic            jump_en_reg;
  logic            jump_reg;
  logic [4:0]      rdsel_reg;
  logic [2:0]      funct3_reg;
  logic [1:0]      off_reg;
  logic [XLEN-1:0] next_pc_reg;
  logic [XLEN-1:0] alu_reg;

  logic [XLEN-1:0] rddata_reg;
  logic [4:0]      rdsel_wr_reg;
  logic            rdwe_reg;
  logic [XLEN-1:0] pc_target_reg;
  logic            jump_wf_reg;
  logic            mem_err_reg;

  logic [UW-1:0]   use_rd_in, use_rd_cur;
  logic            jump_en_cur, jump_cur;
  logic [4:0]      rdsel_cur;
  logic [2:0]      funct3_cur;
  logic [1:0]      off_cur;
  logic [XLEN-1:0] next_pc_cur, alu_cur;
  logic            mem_wait_in;
  logic            unused_op;

  logic [7:0]      lanes [4];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_data, commit_data;

  assign use_rd_in   = wb.decoded_op_mw[USE_RD_BIT_M:USE_RD_BIT_L];
  assign mem_wait_in = (use_rd_in == UW'(USE_RD_MEMORY)) && !wb.mem_valid;
  assign unused_op   = ^wb.decoded_op_mw;

  // In IDLE the commit is computed straight from the inputs; later states use the captured copy.
  always_comb begin
    if (state_reg == IDLE) begin
      use_rd_cur  = use_rd_in;
      jump_en_cur = wb.decoded_op_mw[JUMP_EN_BIT];
      jump_cur    = wb.jump_state_mw;
      rdsel_cur   = wb.rdsel_mw;
      funct3_cur  = wb.funct3_mw;
      off_cur     = wb.mem_off_mw;
      next_pc_cur = wb.next_pc_mw;
      alu_cur     = wb.alu_out_mw;
    end else begin
      use_rd_cur  = use_rd_reg;
      jump_en_cur = jump_en_reg;
      jump_cur    = jump_reg;
      rdsel_cur   = rdsel_reg;
      funct3_cur  = funct3_reg;
      off_cur     = off_reg;
      next_pc_cur = next_pc_reg;
      alu_cur     = alu_reg;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    if (8 * gi + 8 <= XLEN) begin : g_in
      assign lanes[gi] = wb.mem_out_mw[8*gi +: 8];
    end else begin : g_out
      assign lanes[gi] = 8'h00;
    end
  end

  assign sel_byte = lanes[off_cur];
  assign sel_half = {lanes[{off_cur[1], 1'b1}], lanes[{off_cur[1], 1'b0}]};

  always_comb begin
    case (funct3_cur)
      3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
      3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = wb.mem_out_mw;
    endcase
  end

  always_comb begin
    case (use_rd_cur)
      UW'(USE_RD_ALU):    commit_data = alu_cur;
      UW'(USE_RD_PC):     commit_data = next_pc_cur;
      UW'(USE_RD_COMP):   commit_data = {{(XLEN-1){1'b0}}, jump_cur};
      UW'(USE_RD_MEMORY): commit_data = load_data;
      default:            commit_data = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    capture      = 1'b0;
    enter_commit = 1'b0;
    abort        = 1'b0;
    stall        = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = 8'd0;
        if (wb.phase_writeback) begin
          capture = 1'b1;
          if (mem_wait_in) begin
            state_next = WAIT_MEM;
            stall      = 1'b1;
          end else begin
            state_next   = COMMIT;
            enter_commit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        stall = 1'b1;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (wb.mem_valid) begin
          state_next   = COMMIT;
          enter_commit = 1'b1;
        end else if (count_reg == 8'(MEM_TIMEOUT - 1)) begin
          state_next   = COMMIT;
          enter_commit = 1'b1;
          abort        = 1'b1;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        count_next = 8'd0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      use_rd_reg  <= '0;
      jump_en_reg <= 1'b0;
      jump_reg    <= 1'b0;
      rdsel_reg   <= 5'd0;
      funct3_reg  <= 3'd0;
      off_reg     <= 2'd0;
      next_pc_reg <= '0;
      alu_reg     <= '0;
    end else if (capture) begin
      use_rd_reg  <= use_rd_in;
      jump_en_reg <= wb.decoded_op_mw[JUMP_EN_BIT];
      jump_reg    <= wb.jump_state_mw;
      rdsel_reg   <= wb.rdsel_mw;
      funct3_reg  <= wb.funct3_mw;
      off_reg     <= wb.mem_off_mw;
      next_pc_reg <= wb.next_pc_mw;
      alu_reg     <= wb.alu_out_mw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rddata_reg    <= '0;
      rdsel_wr_reg  <= 5'd0;
      rdwe_reg      <= 1'b0;
      pc_target_reg <= '0;
      jump_wf_reg   <= 1'b0;
      mem_err_reg   <= 1'b0;
    end else if (enter_commit) begin
      rddata_reg    <= commit_data;
      rdsel_wr_reg  <= rdsel_cur;
      rdwe_reg      <= (rdsel_cur != 5'd0) && !abort;
      pc_target_reg <= alu_cur;
      jump_wf_reg   <= jump_cur & jump_en_cur;
      mem_err_reg   <= abort;
    end else begin
      rdwe_reg    <= 1'b0;
      mem_err_reg <= 1'b0;
    end
  end

  assign wb.rddata_wr       = rddata_reg;
  assign wb.rdsel_wr        = rdsel_wr_reg;
  assign wb.rdwe_wr         = rdwe_reg;
  assign wb.regdata_for_pc  = pc_target_reg;
  assign wb.jump_state_wf   = jump_wf_reg;
  assign wb.mem_err         = mem_err_reg;
  assign wb.stall_writeback = stall & ~rst;

endmodule
